// File: rtl/kernel_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kernel_sched_pkg
// Brief   : Shared state encoding and widths for the kernel BRAM scheduler.
// Rev     : 1.0  initial release
// ============================================================================
package kernel_sched_pkg;

    localparam int KSCHED_IDX_W = 8;
    localparam int KSCHED_CNT_W = 9;

    // ST_RSVD is never entered; the FSM steers it back to idle if ever decoded.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_REQ = 3'd1,
        ST_LOADING  = 3'd2,
        ST_WAIT_REQ = 3'd3,
        ST_WAIT_LAT = 3'd4,
        ST_NEXT_KER = 3'd5,
        ST_DONE     = 3'd6,
        ST_RSVD     = 3'd7
    } ksched_state_t;

endpackage
`default_nettype wire

// File: rtl/ksched_latency_timer.sv
`default_nettype none
// ============================================================================
// Module  : ksched_latency_timer
// Brief   : Down-counter loaded with READ_LATENCY; o_expire flags the last
//           cycle of the read latency window.
// Rev     : 1.0  initial release
// ============================================================================
module ksched_latency_timer #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_expire
);

    localparam int c_cnt_w = 3;

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_cnt_w'(READ_LATENCY);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign o_expire = (r_cnt == c_cnt_w'(1));

endmodule
`default_nettype wire

// File: rtl/kernel_bram_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : kernel_bram_scheduler
// Brief   : Sequences kernel loads and per-channel reads of kernel_BRAM for a
//           full Conv2d layer. Optional KSCHED_PROTO_CHECK_EN adds proto_err.
// Rev     : 1.0  initial release
// ============================================================================
module kernel_bram_scheduler
    import kernel_sched_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int MAX_OUT_CH   = 256
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [8:0] OUT_CHANNELS,
    input  logic [8:0] CHANNEL_SIZE,
    input  logic       Kernel_BRAM_IDLE,
    input  logic       last_loading_1ker,
    input  logic       last_channel,
    input  logic       ch_req,
    output logic       load_BRAM_dina,
    output logic       update_BRAM_doutb,
    output logic       ker_valid,
    output logic [$clog2(MAX_OUT_CH)-1:0] kernel_idx,
    output logic [KSCHED_IDX_W-1:0]       channel_idx,
    output logic       busy,
    output logic       done
`ifdef KSCHED_PROTO_CHECK_EN
    ,
    output logic       proto_err
`endif
);

    localparam int c_kidx_w = $clog2(MAX_OUT_CH);

    ksched_state_t           r_state;
    logic [KSCHED_CNT_W-1:0] r_out_ch;
    logic [KSCHED_CNT_W-1:0] r_ch_size;
    logic [KSCHED_CNT_W-1:0] r_kernel_cnt;
    logic [KSCHED_CNT_W-1:0] r_ch_cnt;

    logic w_last_ch;
    logic w_last_ker;
    logic w_timer_load;
    logic w_expire;

    // 9-bit compares so a count of 256 terminates correctly
    assign w_last_ch    = (r_ch_cnt == r_ch_size - KSCHED_CNT_W'(1));
    assign w_last_ker   = (r_kernel_cnt == r_out_ch - KSCHED_CNT_W'(1));
    assign w_timer_load = (r_state == ST_WAIT_REQ) && ch_req;

    ksched_latency_timer #(
        .READ_LATENCY (READ_LATENCY)
    ) u_lat_timer (
        .clk      (clk),
        .rst      (Reset),
        .i_load   (w_timer_load),
        .o_expire (w_expire)
    );

    assign kernel_idx = r_kernel_cnt[c_kidx_w-1:0];

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state           <= ST_IDLE;
            r_out_ch          <= '0;
            r_ch_size         <= '0;
            r_kernel_cnt      <= '0;
            r_ch_cnt          <= '0;
            load_BRAM_dina    <= 1'b0;
            update_BRAM_doutb <= 1'b0;
            ker_valid         <= 1'b0;
            channel_idx       <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            load_BRAM_dina    <= 1'b0;
            update_BRAM_doutb <= 1'b0;
            ker_valid         <= 1'b0;
            done              <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_out_ch     <= OUT_CHANNELS;
                        r_ch_size    <= CHANNEL_SIZE;
                        r_kernel_cnt <= '0;
                        r_ch_cnt     <= '0;
                        busy         <= 1'b1;
                        r_state      <= (OUT_CHANNELS == 9'd0) ? ST_DONE : ST_LOAD_REQ;
                    end
                end
                ST_LOAD_REQ: begin
                    if (Kernel_BRAM_IDLE) begin
                        load_BRAM_dina <= 1'b1;
                        r_state        <= ST_LOADING;
                    end
                end
                ST_LOADING: begin
                    if (last_loading_1ker) begin
                        r_ch_cnt <= '0;
                        r_state  <= ST_WAIT_REQ;
                    end
                end
                ST_WAIT_REQ: begin
                    if (ch_req) begin
                        update_BRAM_doutb <= 1'b1;
                        r_state           <= ST_WAIT_LAT;
                    end
                end
                ST_WAIT_LAT: begin
                    if (w_expire) begin
                        ker_valid   <= 1'b1;
                        channel_idx <= r_ch_cnt[KSCHED_IDX_W-1:0];
                        if (w_last_ch) begin
                            r_state <= ST_NEXT_KER;
                        end else begin
                            r_ch_cnt <= r_ch_cnt + KSCHED_CNT_W'(1);
                            r_state  <= ST_WAIT_REQ;
                        end
                    end
                end
                ST_NEXT_KER: begin
                    r_kernel_cnt <= r_kernel_cnt + KSCHED_CNT_W'(1);
                    r_state      <= w_last_ker ? ST_DONE : ST_LOAD_REQ;
                end
                ST_DONE: begin
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    r_kernel_cnt <= '0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef KSCHED_PROTO_CHECK_EN
    // Remembers whether the read now presented was the kernel's last channel
    logic r_valid_last;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_valid_last <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            r_valid_last <= (r_state == ST_WAIT_LAT) && w_expire && w_last_ch;
            if (ker_valid && (last_channel != r_valid_last)) begin
                proto_err <= 1'b1;
            end
            if (last_loading_1ker &&
                ((r_state == ST_WAIT_REQ) || (r_state == ST_WAIT_LAT))) begin
                proto_err <= 1'b1;
            end
        end
    end
`else
    logic w_unused_last_channel;
    assign w_unused_last_channel = last_channel;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kernel_bram_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_kernel_bram_scheduler
// Brief   : Self-checking bench for kernel_bram_scheduler: expected-tag queue
//           model plus directed cycle-exact checks.
// Rev     : 1.0  initial release
// ============================================================================
module tb_kernel_bram_scheduler;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] OUT_CHANNELS = '0;
    logic [8:0] CHANNEL_SIZE = 9'd1;
    logic       kidle = 1'b1;
    logic       last_loading_1ker = 1'b0;
    logic       last_channel = 1'b0;
    logic       ch_req = 1'b1;
    logic       load_BRAM_dina, update_BRAM_doutb, ker_valid, busy, done;
    logic [7:0] kernel_idx, channel_idx;
`ifdef KSCHED_PROTO_CHECK_EN
    logic       proto_err;
`endif

    kernel_bram_scheduler #(.READ_LATENCY(LAT), .MAX_OUT_CH(256)) dut (
        .clk               (clk),
        .Reset             (Reset),
        .start             (start),
        .OUT_CHANNELS      (OUT_CHANNELS),
        .CHANNEL_SIZE      (CHANNEL_SIZE),
        .Kernel_BRAM_IDLE  (kidle),
        .last_loading_1ker (last_loading_1ker),
        .last_channel      (last_channel),
        .ch_req            (ch_req),
        .load_BRAM_dina    (load_BRAM_dina),
        .update_BRAM_doutb (update_BRAM_doutb),
        .ker_valid         (ker_valid),
        .kernel_idx        (kernel_idx),
        .channel_idx       (channel_idx),
        .busy              (busy),
        .done              (done)
`ifdef KSCHED_PROTO_CHECK_EN
        ,
        .proto_err         (proto_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct packed { int k; int c; } tag_t;
    tag_t exp_q[$];
    int   upd_q[$];
    int   kv_k[$];
    int   kv_c[$];
    int   loads_left = 0;
    bit   done_exp = 0;
    bit   model_en = 0;
    bit   ch_rand = 0;
    int   n_load, n_upd, n_kv, n_done, last_k, last_c;
    int   start_cyc, first_load_cyc, done_cyc;
    tag_t t_tag;

    // Random or tied-high channel requests from the engine
    initial forever begin
        @(posedge clk);
        #1 ch_req = ch_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // kernel_BRAM stand-in: a load finishes a few cycles after the pulse
    initial forever begin
        @(posedge clk);
        if (load_BRAM_dina === 1'b1 && !Reset) begin
            repeat (3) @(posedge clk);
            #1 last_loading_1ker = 1'b1;
            @(posedge clk);
            #1 last_loading_1ker = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_en && !Reset) begin
            if (load_BRAM_dina) begin
                check("load_expected", 32'(loads_left > 0), 1);
                check("load_while_busy", 32'(busy), 1);
                loads_left--;
                n_load++;
                if (n_load == 1) first_load_cyc = cyc;
            end
            if (update_BRAM_doutb) begin
                check("update_inflight", upd_q.size(), 0);
                check("update_while_busy", 32'(busy), 1);
                upd_q.push_back(cyc);
                n_upd++;
            end
            if (ker_valid) begin
                check("kv_outstanding", upd_q.size(), 1);
                if (upd_q.size() > 0) check("kv_latency", cyc - upd_q.pop_front(), LAT);
                check("kv_tag_avail", exp_q.size() > 0 ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    t_tag = exp_q.pop_front();
                    check("kv_kernel_idx", 32'(kernel_idx), t_tag.k[7:0]);
                    check("kv_channel_idx", 32'(channel_idx), t_tag.c[7:0]);
                end
                n_kv++;
                last_k = kernel_idx;
                last_c = channel_idx;
                kv_k.push_back(kernel_idx);
                kv_c.push_back(channel_idx);
            end
            if (done) begin
                check("done_expected", 32'(done_exp), 1);
                check("done_tags_left", exp_q.size(), 0);
                check("done_loads_left", loads_left, 0);
                check("done_busy_low", 32'(busy), 0);
                done_exp = 0;
                n_done++;
                done_cyc = cyc;
            end else if (done_exp && cyc > start_cyc) begin
                check("busy_high", 32'(busy), 1);
            end
        end
    end

    // Call at #1 after a posedge; returns one cycle later with start dropped.
    task automatic start_layer(input int oc, input int cs);
        exp_q.delete(); upd_q.delete(); kv_k.delete(); kv_c.delete();
        for (int k = 0; k < oc; k++)
            for (int c = 0; c < cs; c++)
                exp_q.push_back('{k: k, c: c});
        loads_left = oc;
        n_load = 0; n_upd = 0; n_kv = 0; n_done = 0;
        first_load_cyc = -1; done_cyc = -1; last_k = -1; last_c = -1;
        OUT_CHANNELS = 9'(oc);
        CHANNEL_SIZE = 9'(cs);
        start = 1'b1;
        start_cyc = cyc;
        done_exp = 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_within_budget", 32'(n_done), 1);
        @(posedge clk);
        #1;
    endtask

    int lit_k[6] = '{0, 0, 0, 1, 1, 1};
    int lit_c[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_load", 32'(load_BRAM_dina), 0);
        check("rst_update", 32'(update_BRAM_doutb), 0);
        check("rst_ker_valid", 32'(ker_valid), 0);
        check("rst_kernel_idx", 32'(kernel_idx), 0);
        check("rst_channel_idx", 32'(channel_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        Reset = 1'b0;
        model_en = 1;
        @(posedge clk);
        #1;

        // 2 kernels x 3 channels, ch_req tied high
        start_layer(2, 3);
        wait_done(300);
        check("t1_loads", n_load, 2);
        check("t1_updates", n_upd, 6);
        check("t1_kvalids", n_kv, 6);
        check("t1_kv_log_len", kv_k.size(), 6);
        for (int i = 0; i < 6 && i < kv_k.size(); i++) begin
            check("t1_lit_kernel", kv_k[i], lit_k[i]);
            check("t1_lit_channel", kv_c[i], lit_c[i]);
        end
        check("t1_busy_after", 32'(busy), 0);

        // zero output channels: done two cycles after start, nothing issued
        start_layer(0, 5);
        wait_done(20);
        check("t2_done_delay", done_cyc - start_cyc, 2);
        check("t2_loads", n_load, 0);
        check("t2_updates", n_upd, 0);

        // Kernel_BRAM_IDLE low for 10 cycles: load follows the cycle it is seen high
        kidle = 1'b0;
        start_layer(1, 2);
        repeat (10) @(posedge clk);
        #1 kidle = 1'b1;
        wait_done(200);
        check("t3_load_cycle", first_load_cyc - start_cyc, 12);
        check("t3_kvalids", n_kv, 2);

        // random ch_req, large counts at both boundaries
        ch_rand = 1;
        start_layer(2, 256);
        wait_done(8000);
        check("t4a_kvalids", n_kv, 512);
        check("t4a_last_k", last_k, 1);
        check("t4a_last_c", last_c, 255);
        start_layer(256, 2);
        wait_done(20000);
        check("t4b_kvalids", n_kv, 512);
        check("t4b_loads", n_load, 256);
        check("t4b_last_k", last_k, 255);
        check("t4b_last_c", last_c, 1);
        ch_rand = 0;
        @(posedge clk);
        #1;

        // reset while a read is in its latency window
        start_layer(1, 3);
        begin
            int n = 0;
            while (update_BRAM_doutb !== 1'b1 && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("t5_reached_wait_lat", 32'(update_BRAM_doutb), 1);
        model_en = 0;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ker_valid", 32'(ker_valid), 0);
        check("t5_update", 32'(update_BRAM_doutb), 0);
        check("t5_load", 32'(load_BRAM_dina), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_kernel_idx", 32'(kernel_idx), 0);
        check("t5_channel_idx", 32'(channel_idx), 0);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t5_quiet_kv", 32'(ker_valid), 0);
            check("t5_quiet_done", 32'(done), 0);
        end
        exp_q.delete(); upd_q.delete();
        loads_left = 0;
        done_exp = 0;
        model_en = 1;
        start_layer(1, 3);
        wait_done(200);
        check("t5_clean_kvalids", n_kv, 3);
        check("t5_clean_loads", n_load, 1);

`ifdef KSCHED_PROTO_CHECK_EN
        model_en = 0;
        Reset = 1'b1;
        @(posedge clk);
        #1 Reset = 1'b0;
        check("t6_proto_rst", 32'(proto_err), 0);
        model_en = 1;
        last_channel = 1'b1;
        start_layer(1, 3);
        begin
            int n = 0;
            while (n_kv == 0 && n < 100) begin
                @(posedge clk);
                n++;
            end
        end
        @(posedge clk);
        #1;
        check("t6_proto_set", 32'(proto_err), 1);
        wait_done(200);
        check("t6_proto_sticky", 32'(proto_err), 1);
        last_channel = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=%0d required=finish", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
